sipo_frame_ctrl: RTL and testbench

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

---
 rtl/sipo_frame_ctrl.sv | 129 ++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_ctrl.sv
// Serial-in, parallel-out frame receiver: start bit, WIDTH data bits (MSB first),
// optional even-parity bit and a stop bit, delivered through a valid/ready slot.
module sipo_frame_ctrl #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             bit_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             par_err,
  output logic             frm_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               perr_q, perr_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    perr_d      = perr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    par_err_d   = par_err_q;
    frm_err_d   = 1'b0;
    overrun_d   = 1'b0;

    // The consumer handshake runs every cycle; a delivery below may override it.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!in) begin
            state_d = DATA;
            cnt_d   = '0;
            shreg_d = '0;
            perr_d  = 1'b0;
          end
        end
        DATA: begin
          shreg_d = {shreg_q[WIDTH-2:0], in};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          perr_d  = (^shreg_q) ^ in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!in) begin
            frm_err_d = 1'b1;
          end else if (!out_valid_q || out_ready) begin
            out_d       = shreg_q;
            par_err_d   = perr_q;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      perr_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      perr_q      <= perr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign par_err   = par_err_q;
  assign frm_err   = frm_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4, even parity) with hand-computed
// expectations for good frames, parity/framing errors, overrun and mid-frame reset.
module tb_sipo_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       in;
  logic       bit_en;
  logic       out_ready;
  logic [3:0] out;
  logic       out_valid;
  logic       par_err;
  logic       frm_err;
  logic       overrun;
  logic       busy;

  int total;
  int bad;
  int gap;

  sipo_frame_ctrl #(.WIDTH(4), .PARITY_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .bit_en    (bit_en),
    .out_ready (out_ready),
    .out       (out),
    .out_valid (out_valid),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One strobed bit; the line is driven to the opposite level while the strobe is low.
  task automatic send_bit(input logic b);
    in     = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    in     = ~b;
    repeat (gap - 1) @(negedge clk);
    in     = 1'b1;
  endtask

  // Start bit, data MSB first, parity bit; the stop bit is sent by send_stop.
  task automatic applyStimulus(input logic [3:0] data, input logic par);
    send_bit(1'b0);
    for (int i = 3; i >= 0; i--) send_bit(data[i]);
    send_bit(par);
  endtask

  // Stop bit with a chosen out_ready; returns one cycle after the stop edge.
  task automatic send_stop(input logic b, input logic rdy);
    in        = b;
    bit_en    = 1'b1;
    out_ready = rdy;
    @(negedge clk);
    bit_en    = 1'b0;
    out_ready = 1'b0;
    in        = 1'b1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    gap       = 1;
    clk       = 1'b0;
    reset     = 1'b1;
    in        = 1'b1;
    bit_en    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    checkOutput("rst_out",       32'(out),       32'h0);
    checkOutput("rst_valid",     32'(out_valid), 32'h0);
    checkOutput("rst_par_err",   32'(par_err),   32'h0);
    checkOutput("rst_frm_err",   32'(frm_err),   32'h0);
    checkOutput("rst_overrun",   32'(overrun),   32'h0);
    checkOutput("rst_busy",      32'(busy),      32'h0);

    // Good frame 1011, even parity bit 1
    applyStimulus(4'b1011, 1'b1);
    checkOutput("f1_busy_stop",  32'(busy),      32'h1);
    checkOutput("f1_valid_pre",  32'(out_valid), 32'h0);
    send_stop(1'b1, 1'b0);
    checkOutput("f1_out",        32'(out),       32'hb);
    checkOutput("f1_valid",      32'(out_valid), 32'h1);
    checkOutput("f1_par_err",    32'(par_err),   32'h0);
    checkOutput("f1_busy_idle",  32'(busy),      32'h0);
    @(negedge clk);
    checkOutput("f1_hold_valid", 32'(out_valid), 32'h1);
    consume();
    checkOutput("f1_consumed",   32'(out_valid), 32'h0);

    // Same data with wrong parity bit
    applyStimulus(4'b1011, 1'b0);
    send_stop(1'b1, 1'b0);
    checkOutput("f2_out",        32'(out),       32'hb);
    checkOutput("f2_valid",      32'(out_valid), 32'h1);
    checkOutput("f2_par_err",    32'(par_err),   32'h1);
    consume();
    checkOutput("f2_consumed",   32'(out_valid), 32'h0);

    // Framing error: stop bit 0
    applyStimulus(4'b0101, 1'b0);
    send_stop(1'b0, 1'b0);
    checkOutput("f3_frm_err",    32'(frm_err),   32'h1);
    checkOutput("f3_valid",      32'(out_valid), 32'h0);
    checkOutput("f3_busy",       32'(busy),      32'h0);
    @(negedge clk);
    checkOutput("f3_frm_pulse",  32'(frm_err),   32'h0);

    // Back-to-back frames with the slot full: second is dropped
    applyStimulus(4'b0110, 1'b0);
    send_stop(1'b1, 1'b0);
    checkOutput("f4_out",        32'(out),       32'h6);
    applyStimulus(4'b1001, 1'b0);
    send_stop(1'b1, 1'b0);
    checkOutput("f5_overrun",    32'(overrun),   32'h1);
    checkOutput("f5_out_held",   32'(out),       32'h6);
    checkOutput("f5_valid",      32'(out_valid), 32'h1);
    checkOutput("f5_frm_err",    32'(frm_err),   32'h0);
    @(negedge clk);
    checkOutput("f5_ovr_pulse",  32'(overrun),   32'h0);
    consume();
    checkOutput("f5_consumed",   32'(out_valid), 32'h0);

    // Slot freed on the same cycle as the second stop bit
    applyStimulus(4'b0110, 1'b0);
    send_stop(1'b1, 1'b0);
    applyStimulus(4'b1001, 1'b0);
    send_stop(1'b1, 1'b1);
    checkOutput("f6_out",        32'(out),       32'h9);
    checkOutput("f6_valid",      32'(out_valid), 32'h1);
    checkOutput("f6_overrun",    32'(overrun),   32'h0);
    consume();

    // Reset wins over a start bit with bit_en high
    reset = 1'b1; bit_en = 1'b1; in = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; bit_en = 1'b0; in = 1'b1; out_ready = 1'b0;
    checkOutput("rp_busy",       32'(busy),      32'h0);

    for (int g = 1; g <= 3; g += 2) begin
      gap = g;
      // Abandon a frame after its 2nd data bit
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      do_reset();
      checkOutput("mr_out",      32'(out),       32'h0);
      checkOutput("mr_valid",    32'(out_valid), 32'h0);
      checkOutput("mr_busy",     32'(busy),      32'h0);
      checkOutput("mr_frm_err",  32'(frm_err),   32'h0);
      applyStimulus(4'b0011, 1'b0);
      send_stop(1'b1, 1'b0);
      checkOutput("mr_f_out",    32'(out),       32'h3);
      checkOutput("mr_f_valid",  32'(out_valid), 32'h1);
      checkOutput("mr_f_par",    32'(par_err),   32'h0);
      checkOutput("mr_f_frm",    32'(frm_err),   32'h0);
      checkOutput("mr_f_ovr",    32'(overrun),   32'h0);
      consume();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
